// File: rtl/bcd_display_scan_pkg.sv
// Shared definitions for the two-digit BCD display scanner: FSM state encodings
// and the fixed segment patterns used for the "Er" indication and blanking.
package bcd_display_scan_pkg;

    typedef enum logic [1:0] {
        BLANK   = 2'd0,
        SCAN_LO = 2'd1,
        SCAN_HI = 2'd2
    } state_t;

    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_R   = 7'h50;
    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high seven-segment decoder (seg[0]=a .. seg[6]=g).
// Codes above 9 decode to all-off; the caller substitutes the error pattern for those.
module bcd_to_seg7 (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_bcd)
            4'd0: o_seg = 7'h3F;
            4'd1: o_seg = 7'h06;
            4'd2: o_seg = 7'h5B;
            4'd3: o_seg = 7'h4F;
            4'd4: o_seg = 7'h66;
            4'd5: o_seg = 7'h6D;
            4'd6: o_seg = 7'h7D;
            4'd7: o_seg = 7'h07;
            4'd8: o_seg = 7'h7F;
            4'd9: o_seg = 7'h6F;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment driver: latches a BCD product/error on load and
// alternates units/tens every REFRESH_DIV cycles, showing "Er" for invalid products.
// Optional macro BCD_DISPLAY_LZB_EN blanks a leading-zero tens digit.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] bcd_in,
    input  logic       err_in,
    output logic [6:0] seg,
    output logic [1:0] dig_en
);

    localparam int             DW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(REFRESH_DIV - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_div_cnt;
    logic [DW-1:0] w_div_nxt;
    logic [7:0]    r_val;
    logic          r_err;
    logic          w_eff_err;
    logic [3:0]    w_digit;
    logic [6:0]    w_dec_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= BLANK;
            r_div_cnt <= '0;
            r_val     <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            if (load) begin
                r_val <= bcd_in;
                r_err <= err_in;
            end
        end
    end

    assign w_eff_err = r_err | (r_val[7:4] > 4'd9) | (r_val[3:0] > 4'd9);
    assign w_digit   = (r_state == SCAN_HI) ? r_val[7:4] : r_val[3:0];

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // Outputs depend only on registers, so reset clears them without waiting for an edge.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        seg         = SEG_OFF;
        dig_en      = 2'b00;
        case (r_state)
            BLANK: begin
                w_div_nxt = '0;
                if (load) begin
                    w_state_nxt = SCAN_LO;
                end
            end
            SCAN_LO: begin
                dig_en = 2'b01;
                seg    = w_eff_err ? SEG_R : w_dec_seg;
                if (r_div_cnt == DIV_LAST) begin
                    w_state_nxt = SCAN_HI;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            SCAN_HI: begin
                dig_en = 2'b10;
                if (w_eff_err) begin
                    seg = SEG_E;
                end else begin
`ifdef BCD_DISPLAY_LZB_EN
                    seg = (r_val[7:4] == 4'd0) ? SEG_OFF : w_dec_seg;
`else
                    seg = w_dec_seg;
`endif
                end
                if (r_div_cnt == DIV_LAST) begin
                    w_state_nxt = SCAN_LO;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = BLANK;
                w_div_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4; expected per-cycle
// (dig_en, seg) pairs are queued as stimulus is applied and popped at each falling edge.
module tb_bcd_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] bcd_in = 8'h00;
    logic       err_in = 1'b0;
    logic [6:0] seg;
    logic [1:0] dig_en;

    typedef struct packed {
        logic [1:0] dig;
        logic [6:0] sg;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    bcd_display_scan #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bcd_in (bcd_in),
        .err_in (err_in),
        .seg    (seg),
        .dig_en (dig_en)
    );

    always #5 clk = ~clk;

`ifdef BCD_DISPLAY_LZB_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    task automatic push_exp(input logic [1:0] dig, input logic [6:0] sg, input int n);
        exp_t e;
        e.dig = dig;
        e.sg  = sg;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input exp_t e);
        total_cnt++;
        assert ({dig_en, seg} === {e.dig, e.sg}) pass_cnt++;
        else $error("FAIL %s: dig_en=%b seg=%h, expected dig_en=%b seg=%h",
                    tag, dig_en, seg, e.dig, e.sg);
    endtask

    // Each step waits for the falling edge, then checks the oldest queued expectation.
    task automatic check_cycles(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total_cnt++;
                $error("FAIL %s: scoreboard empty at step %0d", tag, i);
            end else begin
                e = exp_q.pop_front();
                cmp(tag, e);
            end
        end
    endtask

    // Called at a falling edge; drives a single-cycle load across the next rising edge.
    task automatic do_load(input logic [7:0] v, input logic e);
        load   = 1'b1;
        bcd_in = v;
        err_in = e;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        // 1: reset state and idle with no load
        #2;
        push_exp(2'b00, 7'h00, 1);
        e = exp_q.pop_front();
        cmp("reset_state", e);
        do_reset();
        push_exp(2'b00, 7'h00, 20);
        check_cycles("idle_blank", 20);

        // 2: 81 alternates units/tens every 4 cycles
        do_load(8'h81, 1'b0);
        push_exp(2'b01, 7'h06, 4);
        push_exp(2'b10, 7'h7F, 4);
        push_exp(2'b01, 7'h06, 4);
        push_exp(2'b10, 7'h7F, 4);
        check_cycles("scan_81", 16);

        // 3: leading-zero tens digit
        do_reset();
        do_load(8'h06, 1'b0);
        push_exp(2'b01, 7'h7D, 4);
        push_exp(2'b10, TENS_ZERO, 4);
        check_cycles("scan_06", 8);

        // 4: error flag and out-of-range digits all show "Er"
        do_reset();
        do_load(8'h12, 1'b1);
        push_exp(2'b01, 7'h50, 4);
        push_exp(2'b10, 7'h79, 4);
        check_cycles("err_flag", 8);
        do_reset();
        do_load(8'h3A, 1'b0);
        push_exp(2'b01, 7'h50, 4);
        push_exp(2'b10, 7'h79, 4);
        check_cycles("units_gt9", 8);
        do_reset();
        do_load(8'hA5, 1'b0);
        push_exp(2'b01, 7'h50, 4);
        push_exp(2'b10, 7'h79, 4);
        check_cycles("tens_gt9", 8);

        // 5: reload mid-phase keeps the phase boundary
        do_reset();
        do_load(8'h81, 1'b0);
        push_exp(2'b01, 7'h06, 2);
        check_cycles("pre_reload", 2);
        do_load(8'h42, 1'b0);
        push_exp(2'b01, 7'h5B, 2);
        push_exp(2'b10, 7'h66, 4);
        push_exp(2'b01, 7'h5B, 4);
        check_cycles("reload_42", 10);

        // load held for three edges: phase counts from the first edge, last value wins
        do_reset();
        load = 1'b1; bcd_in = 8'h11; err_in = 1'b0;
        @(negedge clk); bcd_in = 8'h22;
        @(negedge clk); bcd_in = 8'h33;
        @(posedge clk); #1; load = 1'b0;
        push_exp(2'b01, 7'h4F, 2);
        push_exp(2'b10, 7'h4F, 4);
        check_cycles("held_load", 6);

        // 6: asynchronous reset mid-SCAN_HI
        do_reset();
        do_load(8'h81, 1'b0);
        push_exp(2'b01, 7'h06, 4);
        push_exp(2'b10, 7'h7F, 2);
        check_cycles("pre_rst", 6);
        #2;
        rst = 1'b1;
        #1;
        push_exp(2'b00, 7'h00, 1);
        e = exp_q.pop_front();
        cmp("async_rst", e);
        @(negedge clk);
        rst = 1'b0;
        push_exp(2'b00, 7'h00, 10);
        check_cycles("post_rst_blank", 10);
        do_load(8'h27, 1'b0);
        push_exp(2'b01, 7'h07, 4);
        push_exp(2'b10, 7'h5B, 1);
        check_cycles("post_rst_load", 5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
